// File: rtl/f_fetch_stage_pkg.sv
// Shared fetch-stage constants: reset/handler vectors, text window, exception codes.
// Imported by f_npc and f_fetch_stage.
package f_fetch_stage_pkg;

   localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
   localparam logic [31:0] TEXT_BASE_DEF  = 32'h0000_3000;
   localparam logic [31:0] TEXT_END_DEF   = 32'h0000_6FFC;
   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_RI   = 5'd10;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        exc;
      logic [4:0]  code;
      logic        bd;
   } fd_t;

endpackage

// File: rtl/f_npc.sv
// Next-PC priority mux: exception > eret > stall(hold) > branch/jump > PC+4.
// In: exc_req, eret_req, stall, npc_sel, npc_target, epc, pc. Out: npc.
module f_npc
   import f_fetch_stage_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic        stall,
   input  logic        npc_sel,
   input  logic [31:0] npc_target,
   input  logic [31:0] epc,
   input  logic [31:0] pc,
   output logic [31:0] npc
);

   always_comb begin
      npc = pc + 32'd4;
      if (exc_req)       npc = HANDLER_PC;
      else if (eret_req) npc = epc;
      else if (stall)    npc = pc;
      else if (npc_sel)  npc = npc_target;
   end

endmodule

// File: rtl/f_fetch_stage.sv
// Fetch stage: PC register, fetch-address AdEL check and F/D pipeline register.
// Ports: clk, reset (async low), stall, npc_sel/npc_target, d_is_bj, exc_req,
// eret_req, epc, i_addr/i_rdata (imem), D_Instr/D_PC/D_ExcGet/D_ExcCode/D_BD.
// Optional F_FETCH_COUNT_EN adds fetch_cnt: count of F/D loads of real entries.
module f_fetch_stage
   import f_fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
   parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEF,
   parameter logic [31:0] TEXT_END   = TEXT_END_DEF,
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        npc_sel,
   input  logic [31:0] npc_target,
   input  logic        d_is_bj,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] i_addr,
   input  logic [31:0] i_rdata,
   output logic [31:0] D_Instr,
   output logic [31:0] D_PC,
   output logic        D_ExcGet,
   output logic [4:0]  D_ExcCode,
`ifdef F_FETCH_COUNT_EN
   output logic [31:0] fetch_cnt,
`endif
   output logic        D_BD
);

   logic [31:0] pc_q, pc_d;
   logic        f_exc;
   logic        flush;
   fd_t         fd_q, fd_d;

   f_npc #(
      .HANDLER_PC (HANDLER_PC)
   ) u_npc (
      .exc_req    (exc_req),
      .eret_req   (eret_req),
      .stall      (stall),
      .npc_sel    (npc_sel),
      .npc_target (npc_target),
      .epc        (epc),
      .pc         (pc_q),
      .npc        (pc_d)
   );

   assign f_exc = (pc_q[1:0] != 2'b00)
                | (pc_q < TEXT_BASE)
                | (pc_q > TEXT_END);

   // Exception/eret flush beats stall so the handler or epc starts clean.
   assign flush = exc_req | eret_req;

   always_comb begin
      fd_d = fd_q;
      if (flush) begin
         fd_d       = '0;
         fd_d.pc    = pc_d;
      end else if (!stall) begin
         fd_d.instr = f_exc ? 32'h0 : i_rdata;
         fd_d.pc    = pc_q;
         fd_d.exc   = f_exc;
         fd_d.code  = f_exc ? EXC_ADEL : 5'd0;
         fd_d.bd    = d_is_bj;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= PC_RESET;
         fd_q    <= '0;
         fd_q.pc <= PC_RESET;
      end else begin
         pc_q    <= pc_d;
         fd_q    <= fd_d;
      end
   end

`ifdef F_FETCH_COUNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               cnt_q <= '0;
      else if (!flush && !stall) cnt_q <= cnt_q + 32'd1;
   end

   assign fetch_cnt = cnt_q;
`endif

   assign i_addr    = pc_q;
   assign D_Instr   = fd_q.instr;
   assign D_PC      = fd_q.pc;
   assign D_ExcGet  = fd_q.exc;
   assign D_ExcCode = fd_q.code;
   assign D_BD      = fd_q.bd;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: directed scenarios then random traffic vs a model.
// Honours F_FETCH_COUNT_EN when defined.
module tb_f_fetch_stage;

   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam logic [31:0] TEND = 32'h0000_6FFC;
   localparam logic [31:0] HND  = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, npc_sel, d_is_bj, exc_req, eret_req;
   logic [31:0] npc_target, epc;
   logic [31:0] i_addr, i_rdata, D_Instr, D_PC;
   logic        D_ExcGet, D_BD;
   logic [4:0]  D_ExcCode;
`ifdef F_FETCH_COUNT_EN
   logic [31:0] fetch_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign i_rdata = memf(i_addr);

   f_fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .npc_sel    (npc_sel),
      .npc_target (npc_target),
      .d_is_bj    (d_is_bj),
      .exc_req    (exc_req),
      .eret_req   (eret_req),
      .epc        (epc),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .D_Instr    (D_Instr),
      .D_PC       (D_PC),
      .D_ExcGet   (D_ExcGet),
      .D_ExcCode  (D_ExcCode),
`ifdef F_FETCH_COUNT_EN
      .fetch_cnt  (fetch_cnt),
`endif
      .D_BD       (D_BD)
   );

   // Reference model state
   logic [31:0] m_pc, m_instr, m_dpc, m_cnt;
   logic        m_exc, m_bd;
   logic [4:0]  m_code;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = BASE; m_instr = 0; m_dpc = BASE;
      m_exc = 0; m_code = 0; m_bd = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      logic        legal;
      logic [31:0] nxt;
      legal = (m_pc % 4 == 0) && (m_pc >= BASE) && (m_pc <= TEND);
      if (exc_req)       nxt = HND;
      else if (eret_req) nxt = epc;
      else if (stall)    nxt = m_pc;
      else if (npc_sel)  nxt = npc_target;
      else               nxt = m_pc + 4;
      if (exc_req || eret_req) begin
         m_instr = 0; m_dpc = nxt; m_exc = 0; m_code = 0; m_bd = 0;
      end else if (!stall) begin
         m_instr = legal ? memf(m_pc) : 32'h0;
         m_dpc   = m_pc;
         m_exc   = !legal;
         m_code  = legal ? 5'd0 : 5'd4;
         m_bd    = d_is_bj;
         m_cnt   = m_cnt + 1;
      end
      m_pc = nxt;
   endtask

   task automatic check_all();
      chk("i_addr", i_addr, m_pc);
      chk("D_Instr", D_Instr, m_instr);
      chk("D_PC", D_PC, m_dpc);
      chk("D_ExcGet", {31'd0, D_ExcGet}, {31'd0, m_exc});
      chk("D_ExcCode", {27'd0, D_ExcCode}, {27'd0, m_code});
      chk("D_BD", {31'd0, D_BD}, {31'd0, m_bd});
`ifdef F_FETCH_COUNT_EN
      chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
   endtask

   task automatic step(input logic st, input logic ns,
                       input logic [31:0] tgt, input logic bj,
                       input logic ex, input logic er,
                       input logic [31:0] ep);
      stall = st; npc_sel = ns; npc_target = tgt; d_is_bj = bj;
      exc_req = ex; eret_req = er; epc = ep;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0, 0, 32'h0);
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0:       a = 32'h0000_2000 + ($urandom_range(0, 255) << 2);
         1:       a = 32'h0000_7000 + ($urandom_range(0, 255) << 2);
         2:       a = BASE + $urandom_range(0, 4095);
         default: a = BASE + ($urandom_range(0, 4095) << 2);
      endcase
      return a;
   endfunction

   initial begin
      logic [31:0] c0;
      reset = 0; stall = 0; npc_sel = 0; d_is_bj = 0;
      exc_req = 0; eret_req = 0; npc_target = 0; epc = 0;
      model_reset();
      #12;
      check_all();
      reset = 1;

      // Run to 0x3010, then async reset mid-cycle
      repeat (4) idle();
      chk("pc_pre_reset", i_addr, 32'h3010);
      #2 reset = 0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      reset = 1;
      idle();
      idle();
      chk("after_release", i_addr, 32'h3008);

      // Stall two cycles at 0x3008
      step(1, 0, 32'h0, 0, 0, 0, 32'h0);
      step(1, 0, 32'h0, 0, 0, 0, 32'h0);
      chk("stall_hold_pc", i_addr, 32'h3008);
      chk("stall_hold_dpc", D_PC, 32'h3004);
      // Branch taken from D with 0x3008 as delay slot
      step(0, 1, 32'h3100, 1, 0, 0, 32'h0);
      chk("bd_set", {31'd0, D_BD}, 32'd1);
      chk("bd_dpc", D_PC, 32'h3008);
      chk("br_target", i_addr, 32'h3100);

      // Illegal targets: misaligned, below, above
      foreach (c0[i]) if (i < 3) begin
         logic [31:0] t;
         t = (i == 0) ? 32'h3102 : (i == 1) ? 32'h2FFC : 32'h7000;
         step(0, 1, t, 0, 0, 0, 32'h0);
         idle();
         chk("adel_flag", {31'd0, D_ExcGet}, 32'd1);
         chk("adel_code", {27'd0, D_ExcCode}, 32'd4);
         chk("adel_pc", D_PC, t);
      end

      // Exception beats stall and branch
      step(0, 1, 32'h3020, 0, 0, 0, 32'h0);
      step(1, 1, 32'h3100, 1, 1, 0, 32'h0);
      chk("exc_pc", i_addr, HND);
      chk("exc_bubble", D_Instr, 32'h0);

      // ERET resumes at epc, flushes, no count
`ifdef F_FETCH_COUNT_EN
      c0 = fetch_cnt;
`endif
      step(0, 0, 32'h0, 0, 0, 1, 32'h3044);
      chk("eret_pc", i_addr, 32'h3044);
      chk("eret_flush", D_Instr, 32'h0);
`ifdef F_FETCH_COUNT_EN
      chk("eret_nocnt", fetch_cnt, c0);
`endif

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              pick_addr(), $urandom_range(0, 1) == 1,
              $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
              pick_addr());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
